// File: rtl/chimera_clu_iso_ctrl.sv
// -----------------------------------------------------------------------------
// chimera_clu_iso_ctrl
//
// Per-cluster isolation and reset sequencer. For every cluster it raises the
// isolate request of all of that cluster's AXI isolation ports and waits until
// every port reports isolated. While the cluster is fenced it can pulse a
// cluster-local reset, and it drops isolation again in order. Drain and release
// phases are bounded by a timeout that parks the cluster in a fault state
// with a sticky flag until software acknowledges it.
//
// Ports
//   soc_clk_i   : SoC clock, all flops on the rising edge
//   rst_i       : asynchronous active-high reset
//   iso_req_i   : per cluster, level, 1 = cluster should be isolated
//   rst_req_i   : per cluster, 1-cycle pulse, request a cluster reset
//   clear_i     : per cluster, 1-cycle pulse, acknowledge a fault
//   isolated_i  : per port isolated status, cluster k owns [k*C +: C]
//   isolate_o   : per port isolate request
//   clu_rst_no  : per cluster active-low reset
//   state_o     : 3-bit FSM state per cluster
//   timeout_o   : per cluster sticky fault flag
//   done_o      : per cluster 1-cycle pulse on entry to ISOLATED or ACTIVE
//
// Every output is a decode of registered state only; no input reaches an
// output without passing through a flop.
// -----------------------------------------------------------------------------
module chimera_clu_iso_ctrl #(
    parameter int NumClusters   = 2,
    parameter int ChansPerClu   = 4,
    parameter int TimeoutCycles = 256,
    parameter int ResetCycles   = 16,
    parameter bit ResetIsolated = 1'b0
) (
    input  logic                                 soc_clk_i,
    input  logic                                 rst_i,
    input  logic [NumClusters-1:0]               iso_req_i,
    input  logic [NumClusters-1:0]               rst_req_i,
    input  logic [NumClusters-1:0]               clear_i,
    input  logic [NumClusters*ChansPerClu-1:0]   isolated_i,
    output logic [NumClusters*ChansPerClu-1:0]   isolate_o,
    output logic [NumClusters-1:0]               clu_rst_no,
    output logic [3*NumClusters-1:0]             state_o,
    output logic [NumClusters-1:0]               timeout_o,
    output logic [NumClusters-1:0]               done_o
);

    localparam int MaxCnt = (TimeoutCycles > ResetCycles) ? TimeoutCycles : ResetCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);

    // Terminal counts: the counter starts at 0 on phase entry, so the last
    // cycle of a phase of length N sees count N-1.
    localparam logic [CntW-1:0] ToLast  = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] RstLast = CntW'((ResetCycles > 0) ? ResetCycles - 1 : 0);
    localparam bit              ToEn    = (TimeoutCycles > 0);

    localparam logic [2:0] ST_ACTIVE   = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_ISOLATED = 3'd2;
    localparam logic [2:0] ST_RESET    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    localparam logic [2:0] ST_POR = ResetIsolated ? ST_ISOLATED : ST_ACTIVE;

    genvar gi;
    generate
        for (gi = 0; gi < NumClusters; gi++) begin : g_clu
            logic [2:0]      state_reg, state_next;
            logic [CntW-1:0] cnt_reg, cnt_next;
            logic            pend_reg, pend_next;
            logic            tmo_reg, tmo_next;
            logic            done_reg, done_next;
            logic            all_iso, none_iso, want_rst, cnt_to;
            logic            iso_dec, rst_n_dec;

            assign all_iso  = &isolated_i[gi*ChansPerClu +: ChansPerClu];
            assign none_iso = ~|isolated_i[gi*ChansPerClu +: ChansPerClu];
            // The live pulse counts as well as the latched one, so a reset
            // request arriving together with iso_req_i falling in ISOLATED
            // still takes the reset path first.
            assign want_rst = pend_reg | rst_req_i[gi];
            assign cnt_to   = ToEn && (cnt_reg == ToLast);

            // State register
            always_ff @(posedge soc_clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_reg <= ST_POR;
                    cnt_reg   <= '0;
                    pend_reg  <= 1'b0;
                    tmo_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    pend_reg  <= pend_next;
                    tmo_reg   <= tmo_next;
                    done_reg  <= done_next;
                end
            end

            // Next-state and bookkeeping logic
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_ACTIVE: begin
                        if (iso_req_i[gi] || want_rst) state_next = ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (all_iso)     state_next = ST_ISOLATED;
                        else if (cnt_to) state_next = ST_FAULT;
                    end
                    ST_ISOLATED: begin
                        if (want_rst)            state_next = ST_RESET;
                        else if (!iso_req_i[gi]) state_next = ST_RELEASE;
                    end
                    ST_RESET: begin
                        if (cnt_reg == RstLast) state_next = ST_ISOLATED;
                    end
                    ST_RELEASE: begin
                        // A renewed isolate request aborts the release.
                        if (iso_req_i[gi])  state_next = ST_DRAIN;
                        else if (none_iso)  state_next = ST_ACTIVE;
                        else if (cnt_to)    state_next = ST_FAULT;
                    end
                    ST_FAULT: begin
                        if (clear_i[gi]) state_next = ST_RESET;
                    end
                    default: state_next = ST_FAULT;
                endcase

                // Counter restarts on every state change and only runs in the
                // timed phases.
                cnt_next = '0;
                if (state_next == state_reg &&
                    (state_reg == ST_DRAIN || state_reg == ST_RESET || state_reg == ST_RELEASE)) begin
                    cnt_next = cnt_reg + CntW'(1);
                end

                pend_next = pend_reg;
                if (state_next == ST_RESET && state_reg != ST_RESET) begin
                    pend_next = 1'b0;
                end else if (rst_req_i[gi] && state_reg != ST_RESET && state_reg != ST_FAULT) begin
                    pend_next = 1'b1;
                end

                // Setting on fault entry wins over a simultaneous wipe.
                tmo_next = tmo_reg;
                if (state_next == ST_FAULT && state_reg != ST_FAULT) begin
                    tmo_next = 1'b1;
                end else if (clear_i[gi] && tmo_reg && state_reg != ST_FAULT) begin
                    tmo_next = 1'b0;
                end

                done_next = (state_next != state_reg) &&
                            (state_next == ST_ISOLATED || state_next == ST_ACTIVE);
            end

            // Output decode from registered state
            always_comb begin
                iso_dec   = 1'b1;
                rst_n_dec = 1'b1;
                case (state_reg)
                    ST_ACTIVE:   begin iso_dec = 1'b0; rst_n_dec = 1'b1; end
                    ST_DRAIN:    begin iso_dec = 1'b1; rst_n_dec = 1'b1; end
                    ST_ISOLATED: begin iso_dec = 1'b1; rst_n_dec = 1'b1; end
                    ST_RESET:    begin iso_dec = 1'b1; rst_n_dec = 1'b0; end
                    ST_RELEASE:  begin iso_dec = 1'b0; rst_n_dec = 1'b1; end
                    default:     begin iso_dec = 1'b1; rst_n_dec = 1'b0; end
                endcase
            end

            assign isolate_o[gi*ChansPerClu +: ChansPerClu] = {ChansPerClu{iso_dec}};
            assign clu_rst_no[gi]     = rst_n_dec;
            assign state_o[3*gi +: 3] = state_reg;
            assign timeout_o[gi]      = tmo_reg;
            assign done_o[gi]         = done_reg;
        end
    endgenerate

endmodule
